// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Receive-side checker for a VGA sync stream. Measures line length, hsync
// width, frame height and vsync width on the pixel tick. Compares every frame
// against the expected timing and runs a SEARCH/TRACK/LOCKED state machine.
// Frame and error counters are read back through a simple register read port.
`timescale 1ns/1ps
module vga_timing_monitor #(
  parameter int CNT_W       = 12,
  parameter int EXP_HTOTAL  = 800,
  parameter int EXP_HSYNC   = 96,
  parameter int EXP_VTOTAL  = 525,
  parameter int EXP_VSYNC   = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,   // active-high despite the name
  input  logic        pix_tick,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        slv_reg_rden,
  input  logic [2:0]  axi_araddr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        locked,
  output logic        err_irq
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_HT  = CNT_W'(EXP_HTOTAL);
  localparam logic [CNT_W-1:0] EXP_HS  = CNT_W'(EXP_HSYNC);
  localparam logic [CNT_W-1:0] EXP_VT  = CNT_W'(EXP_VTOTAL);
  localparam logic [CNT_W-1:0] EXP_VS  = CNT_W'(EXP_VSYNC);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  // Synchronisers and edge history
  logic hs_meta_q, hs_sync_q, vs_meta_q, vs_sync_q;
  logic hs_prev_q, vs_prev_q;

  // Measurements
  logic [CNT_W-1:0] hcnt_q, hlow_q, meas_htotal_q, meas_hsync_q;
  logic [CNT_W-1:0] vline_q, vlow_q, meas_vtotal_q, meas_vsync_q;
  logic             armed_q;

  // FSM and counters
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [15:0] frame_cnt_q, err_cnt_q;
  logic        err_evt, frame_inc, timeout, frame_good;
  logic        err_irq_q, rd_valid_q;
  logic [31:0] rd_data_q, rd_mux;

  logic hs_fall, hs_rise, vs_fall, vs_rise, err_clr;
  logic [CNT_W-1:0] vtotal_new;

  // hsync edges only count on a pixel tick; vsync is sampled at hsync falls.
  assign hs_fall    = pix_tick &  hs_prev_q & ~hs_sync_q;
  assign hs_rise    = pix_tick & ~hs_prev_q &  hs_sync_q;
  assign vs_fall    = hs_fall  &  vs_prev_q & ~vs_sync_q;
  assign vs_rise    = hs_fall  & ~vs_prev_q &  vs_sync_q;
  assign vtotal_new = sat_inc(vline_q);
  assign timeout    = armed_q & (hcnt_q == CNT_MAX);
  assign err_clr    = slv_reg_rden & (axi_araddr == 3'd6);
  assign frame_good = (meas_htotal_q == EXP_HT) && (meas_hsync_q == EXP_HS) &&
                      (vtotal_new == EXP_VT) && (meas_vsync_q == EXP_VS);

  // Two-flop synchronisers; idle level of both syncs is high.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
    end else begin
      hs_meta_q <= hsync_in;
      hs_sync_q <= hs_meta_q;
      vs_meta_q <= vsync_in;
      vs_sync_q <= vs_meta_q;
    end
  end

  // Horizontal measurement: line length between hsync falls, hsync low width.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      hs_prev_q     <= 1'b1;
      hcnt_q        <= '0;
      hlow_q        <= '0;
      meas_htotal_q <= '0;
      meas_hsync_q  <= '0;
    end else if (pix_tick) begin
      hs_prev_q <= hs_sync_q;
      if (hs_fall) begin
        meas_htotal_q <= sat_inc(hcnt_q);
        hcnt_q        <= '0;
      end else begin
        hcnt_q <= sat_inc(hcnt_q);
      end
      if (hs_rise) begin
        meas_hsync_q <= hlow_q;
        hlow_q       <= '0;
      end else if (!hs_sync_q) begin
        hlow_q <= sat_inc(hlow_q);
      end
    end
  end

  // Vertical measurement in lines; the capturing hsync edge counts as a line.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      vs_prev_q     <= 1'b1;
      vline_q       <= '0;
      vlow_q        <= '0;
      meas_vtotal_q <= '0;
      meas_vsync_q  <= '0;
    end else if (hs_fall) begin
      vs_prev_q <= vs_sync_q;
      if (vs_fall) begin
        meas_vtotal_q <= vtotal_new;
        vline_q       <= '0;
      end else begin
        vline_q <= vtotal_new;
      end
      if (vs_rise) begin
        meas_vsync_q <= vlow_q;
        vlow_q       <= '0;
      end else if (!vs_sync_q) begin
        vlow_q <= sat_inc(vlow_q);
      end
    end
  end

  // Loss-of-hsync detector fires once, re-armed by the next hsync fall.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN)  armed_q <= 1'b1;
    else if (hs_fall)   armed_q <= 1'b1;
    else if (timeout)   armed_q <= 1'b0;
  end

  // Lock FSM next-state: timeout beats any frame decision in the same cycle.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_evt    = 1'b0;
    frame_inc  = 1'b0;
    if (timeout) begin
      state_d    = SEARCH;
      good_cnt_d = 4'd0;
      err_evt    = 1'b1;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH: begin
          state_d    = TRACK;
          good_cnt_d = 4'd0;
        end
        TRACK: begin
          frame_inc = 1'b1;
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_cnt_d = 4'd0;
            err_evt    = 1'b1;
          end
        end
        LOCKED: begin
          frame_inc = 1'b1;
          if (!frame_good) begin
            state_d    = TRACK;
            good_cnt_d = 4'd0;
            err_evt    = 1'b1;
          end
        end
        default: begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // FSM state, frame/error counters; an error increment beats clear-on-read.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      state_q     <= SEARCH;
      good_cnt_q  <= 4'd0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_irq_q  <= err_evt;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_evt) begin
        if (err_clr)                    err_cnt_q <= 16'd1;
        else if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (err_clr) begin
        err_cnt_q <= 16'd0;
      end
    end
  end

  // Register map decode.
  always_comb begin
    rd_mux = 32'd0;
    case (axi_araddr)
      3'd0:    rd_mux = {27'd0, good_cnt_q[2:0], state_q};
      3'd1:    rd_mux = 32'(meas_htotal_q);
      3'd2:    rd_mux = 32'(meas_hsync_q);
      3'd3:    rd_mux = 32'(meas_vtotal_q);
      3'd4:    rd_mux = 32'(meas_vsync_q);
      3'd5:    rd_mux = {16'd0, frame_cnt_q};
      3'd6:    rd_mux = {16'd0, err_cnt_q};
      default: rd_mux = 32'd0;
    endcase
  end

  // Read port: data registered one cycle after the strobe and held.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
    if (S_AXI_ARESETN) begin
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= slv_reg_rden;
      if (slv_reg_rden) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err_irq  = err_irq_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
// Drives a scaled-down VGA timing (32 ticks x 16 lines) with a free-running
// pixel-level generator and checks the monitor against a frame-level model.
`timescale 1ns/1ps
module tb_vga_timing_monitor;

  localparam int H    = 32;
  localparam int HSW  = 4;
  localparam int HSS  = 20;
  localparam int V    = 16;
  localparam int VSW  = 2;
  localparam int VSS  = 12;
  localparam int LOCK = 2;
  localparam int CW   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_tick = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        rden = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] rd_data;
  logic        rd_valid, locked, err_irq;

  int n_tests = 0;
  int n_fail  = 0;

  // generator state
  int gh = 0, gv = 0, div = 0;
  int long_req = 0, long_done = 0;
  bit hold_hs = 1'b0;
  int irq_cnt = 0;

  // frame-level reference model
  int m_state = 0, m_good = 0, m_frame = 0, m_err = 0, m_irq = 0;

  vga_timing_monitor #(
    .CNT_W(CW), .EXP_HTOTAL(H), .EXP_HSYNC(HSW), .EXP_VTOTAL(V),
    .EXP_VSYNC(VSW), .LOCK_FRAMES(LOCK)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst), .pix_tick(pix_tick),
    .hsync_in(hsync), .vsync_in(vsync), .slv_reg_rden(rden),
    .axi_araddr(addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .locked(locked), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  // Pixel-level sync generator: tick every 4 clocks, optional long line
  // (line VSS-2) and optional forced-high hsync.
  initial begin
    forever begin
      int len;
      @(negedge clk);
      pix_tick = 1'b0;
      div = (div + 1) % 4;
      if (div == 0) begin
        pix_tick = 1'b1;
        len = H + ((long_done < long_req && gv == VSS - 2) ? 1 : 0);
        gh++;
        if (gh >= len) begin
          gh = 0;
          if (len > H) long_done++;
          gv = (gv + 1) % V;
        end
      end
      hsync = hold_hs ? 1'b1 : !(gh >= HSS && gh < HSS + HSW);
      vsync = !(gv >= VSS && gv < VSS + VSW);
    end
  end

  // Count interrupt pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (err_irq) irq_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_vs(input bit good);
    if (m_state == 0) begin
      m_state = 1;
      m_good  = 0;
    end else begin
      m_frame = (m_frame + 1) % 65536;
      if (good) begin
        if (m_state == 1) begin
          m_good++;
          if (m_good >= LOCK) m_state = 2;
        end
      end else begin
        m_good  = 0;
        m_state = 1;
        if (m_err < 65535) m_err++;
        m_irq++;
      end
    end
  endfunction

  function automatic int exp_reg(input int a);
    case (a)
      0: return (m_good % 8) * 4 + m_state;
      1: return H;
      2: return HSW;
      3: return V;
      4: return VSW;
      5: return m_frame;
      6: return m_err;
      default: return 0;
    endcase
  endfunction

  task automatic rd(input int a, output logic [31:0] d, output logic v);
    @(negedge clk);
    rden = 1'b1;
    addr = 3'(a);
    @(negedge clk);
    rden = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic rd_chk(input int a, input string tag);
    logic [31:0] d;
    logic v;
    int e;
    e = exp_reg(a);
    rd(a, d, v);
    if (a == 6) m_err = 0;
    check(tag, d, 32'(e));
  endtask

  task automatic wait_pos(input int v, input int h, input string tag);
    int k = 0;
    while (!(gv == v && gh == h) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 6000), 32'd1);
  endtask

  // Wait until the DUT has seen the next vsync fall.
  task automatic wait_vs();
    int k = 0;
    while (gv == VSS && k < 200) begin
      @(negedge clk);
      k++;
    end
    wait_pos(VSS, HSS + 4, "vs_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input bit good, input string tag);
    wait_vs();
    m_vs(good);
    $display("[TB] %s: good=%0d state=%0d locked_exp=%0d", tag, good, m_state, m_state == 2);
    check({tag, "_locked"}, 32'(locked), 32'(m_state == 2));
    check({tag, "_irq"}, 32'(irq_cnt), 32'(m_irq));
    rd_chk(0, {tag, "_reg0"});
  endtask

  initial begin
    logic [31:0] d;
    logic v;
    int n, sum, strobes, vals, k;

    // ---- reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_rdvalid", 32'(rd_valid), 32'd0);
    check("rst_irq", 32'(err_irq), 32'd0);
    check("rst_rddata", rd_data, 32'd0);
    wait_pos(1 + int'($urandom % 8), int'($urandom % 8), "rel_wait");
    rst = 1'b0;
    for (int a = 0; a < 7; a++) begin
      rd(a, d, v);
      check($sformatf("rst_reg%0d", a), d, 32'd0);
    end

    // ---- 1: acquire lock, measurements
    for (int i = 0; i < 4; i++) frame(1'b1, $sformatf("acq%0d", i));
    for (int a = 1; a <= 6; a++) rd_chk(a, $sformatf("meas_reg%0d", a));
    repeat (4) begin
      n = int'($urandom % 6);
      rd_chk(n, $sformatf("rand_reg%0d", n));
    end

    // ---- 2: one long line while locked
    long_req++;
    frame(1'b0, "long1");
    check("long1_state", 32'(locked), 32'd0);
    frame(1'b1, "relock1a");
    frame(1'b1, "relock1b");

    // ---- 3: loss of hsync
    wait_pos(2, 0, "hold_wait");
    hold_hs = 1'b1;
    n = 70 + int'($urandom % 20);
    repeat (n * 4) @(negedge clk);
    hold_hs = 1'b0;
    m_state = 0;
    m_good  = 0;
    m_err++;
    m_irq++;
    repeat (2) @(negedge clk);
    $display("[TB] timeout: hold=%0d ticks", n);
    check("to_irq", 32'(irq_cnt), 32'(m_irq));
    check("to_locked", 32'(locked), 32'd0);
    rd(0, d, v);
    check("to_state", d & 32'd3, 32'd0);
    for (int i = 0; i < 3; i++) frame(1'b1, $sformatf("relock2_%0d", i));

    // ---- 4: clear-on-read
    long_req++;
    frame(1'b0, "long2");
    rd(6, d, v);
    check("err3_data", d, 32'(m_err));
    check("err3_valid", 32'(v), 32'd1);
    m_err = 0;
    @(negedge clk);
    check("err3_valid_drop", 32'(rd_valid), 32'd0);
    rd_chk(6, "err_reread");
    // read addr 6 every cycle across an error event
    long_req++;
    wait_pos(VSS - 1, 0, "coin_wait");
    sum = 0; strobes = 0; vals = 0; k = 0;
    while (!(gv == VSS && gh == HSS + 4) && k < 3000) begin
      @(negedge clk);
      if (rd_valid) begin vals++; sum += int'(rd_data); end
      rden = 1'b1;
      addr = 3'd6;
      strobes++;
      k++;
    end
    @(negedge clk);
    if (rd_valid) begin vals++; sum += int'(rd_data); end
    rden = 1'b0;
    @(negedge clk);
    if (rd_valid) begin vals++; sum += int'(rd_data); end
    m_vs(1'b0);
    m_err = 0;
    $display("[TB] coincide: strobes=%0d valids=%0d sum=%0d", strobes, vals, sum);
    check("coin_sum", 32'(sum), 32'd1);
    check("coin_valids", 32'(vals), 32'(strobes));
    check("coin_irq", 32'(irq_cnt), 32'(m_irq));
    rd_chk(0, "coin_reg0");
    rd_chk(6, "coin_err");
    frame(1'b1, "relock3a");
    frame(1'b1, "relock3b");

    // ---- 5: reset mid-frame while locked
    rd_chk(1, "pre_rst_htotal");
    wait_pos(1 + int'($urandom % 8), int'($urandom % 10), "rst2_wait");
    #2 rst = 1'b1;
    #1;
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_rddata", rd_data, 32'd0);
    check("rst2_rdvalid", 32'(rd_valid), 32'd0);
    check("rst2_irq", 32'(err_irq), 32'd0);
    m_state = 0; m_good = 0; m_frame = 0; m_err = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rd_chk(0, "rst2_reg0");
    rd_chk(5, "rst2_frame");
    for (int i = 0; i < 3; i++) frame(1'b1, $sformatf("relock4_%0d", i));

    // ---- 6: addr 7 and back-to-back reads
    rd_chk(7, "reg7");
    @(negedge clk);
    rden = 1'b1;
    addr = 3'd1;
    @(negedge clk);
    addr = 3'd3;
    check("b2b_valid1", 32'(rd_valid), 32'd1);
    check("b2b_data1", rd_data, 32'(H));
    @(negedge clk);
    rden = 1'b0;
    check("b2b_valid2", 32'(rd_valid), 32'd1);
    check("b2b_data2", rd_data, 32'(V));
    @(negedge clk);
    check("b2b_valid3", 32'(rd_valid), 32'd0);
    rd_chk(5, "final_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
